// File: rtl/ap_handshake_profiler.sv
// Watches an ap_ctrl handshake and queues one record per kernel invocation:
// invocation id, cycle latency, completed loop iterations and stage-0 stall cycles.
module ap_handshake_profiler #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             prof_en,
  input  logic             ap_start,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             iter_end,
  input  logic             loop_block,
  output logic             busy,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [15:0]      rec_id,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_iters,
  output logic [CNT_W-1:0] rec_stalls,
  output logic [15:0]      drop_cnt
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [OW-1:0]    FULL_CNT = OW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WAIT_CONT = 2'd2} state_t;

  state_t           state;
  logic [CNT_W-1:0] lat_q, iters_q, stalls_q;
  logic [15:0]      id_q;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [OW-1:0]    count;

  logic [15:0]      mem_id     [DEPTH];
  logic [CNT_W-1:0] mem_lat    [DEPTH];
  logic [CNT_W-1:0] mem_iters  [DEPTH];
  logic [CNT_W-1:0] mem_stalls [DEPTH];

  logic             start_c, active_c, push_c, pop_c, full_c, accept_c, drop_c, bypass_c;
  logic [CNT_W-1:0] lat_nx_c, iters_nx_c, stalls_nx_c;
  logic [AW-1:0]    rd_ptr_nx_c;
  logic [OW-1:0]    count_nx_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  // Counter values including this cycle, and FIFO push/pop decisions.
  always_comb begin
    start_c     = (state == IDLE) && prof_en && ap_start;
    active_c    = start_c || (state == RUN);
    push_c      = active_c && ap_done;
    pop_c       = rec_valid && rec_ready;
    full_c      = (count == FULL_CNT);
    accept_c    = push_c && (!full_c || pop_c);
    drop_c      = push_c && full_c && !pop_c;
    lat_nx_c    = start_c ? CNT_W'(1)          : sat_inc(lat_q, 1'b1);
    iters_nx_c  = start_c ? CNT_W'(iter_end)   : sat_inc(iters_q, iter_end);
    stalls_nx_c = start_c ? CNT_W'(loop_block) : sat_inc(stalls_q, loop_block);
    rd_ptr_nx_c = pop_c ? rd_ptr + AW'(1) : rd_ptr;
    count_nx_c  = count + OW'(accept_c) - OW'(pop_c);
    // A record landing in a FIFO that is empty after this cycle's pop becomes the head directly.
    bypass_c    = accept_c && (wr_ptr == rd_ptr_nx_c);
  end

  // Invocation tracking FSM with its counters and id/drop bookkeeping.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      lat_q    <= '0;
      iters_q  <= '0;
      stalls_q <= '0;
      id_q     <= '0;
      drop_cnt <= '0;
    end else begin
      if (active_c) begin
        lat_q    <= lat_nx_c;
        iters_q  <= iters_nx_c;
        stalls_q <= stalls_nx_c;
      end
      case (state)
        IDLE, RUN: begin
          if (active_c) begin
            if (!ap_done) begin
              state <= RUN;
              busy  <= 1'b1;
            end else if (ap_continue) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= WAIT_CONT;
              busy  <= 1'b1;
            end
          end
        end
        WAIT_CONT: begin
          if (ap_continue) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (push_c) id_q <= id_q + 16'd1;
      if (drop_c && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // FIFO pointers and registered head outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rec_valid   <= 1'b0;
      rec_id      <= '0;
      rec_latency <= '0;
      rec_iters   <= '0;
      rec_stalls  <= '0;
    end else begin
      if (accept_c) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_ptr_nx_c;
      count     <= count_nx_c;
      rec_valid <= (count_nx_c != '0);
      if (bypass_c) begin
        rec_id      <= id_q;
        rec_latency <= lat_nx_c;
        rec_iters   <= iters_nx_c;
        rec_stalls  <= stalls_nx_c;
      end else if (pop_c) begin
        rec_id      <= mem_id[rd_ptr_nx_c];
        rec_latency <= mem_lat[rd_ptr_nx_c];
        rec_iters   <= mem_iters[rd_ptr_nx_c];
        rec_stalls  <= mem_stalls[rd_ptr_nx_c];
      end
    end
  end

  // Record storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge ap_clk) begin
    if (accept_c) begin
      mem_id[wr_ptr]     <= id_q;
      mem_lat[wr_ptr]    <= lat_nx_c;
      mem_iters[wr_ptr]  <= iters_nx_c;
      mem_stalls[wr_ptr] <= stalls_nx_c;
    end
  end

endmodule

// File: tb/tb_ap_handshake_profiler.sv
// Bench for ap_handshake_profiler: directed scenarios plus randomized traffic
// checked against an invocation-level record model.
`timescale 1ns/1ps
module tb_ap_handshake_profiler;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned DEPTH = 4;
  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

  logic ap_clk, ap_rst_n;
  logic prof_en, ap_start, ap_done, ap_continue, iter_end, loop_block, rec_ready;
  logic busy, rec_valid;
  logic [15:0] rec_id, drop_cnt;
  logic [CNT_W-1:0] rec_latency, rec_iters, rec_stalls;
  logic s_busy, s_rec_valid;
  logic [15:0] s_rec_id, s_drop_cnt;
  logic [3:0] s_rec_latency, s_rec_iters, s_rec_stalls;

  int errors = 0;
  int checks = 0;

  typedef struct { int id; longint lat; longint it; longint st; } rec_t;
  rec_t mq[$];
  int m_state, m_id, m_drop;
  longint m_lat, m_it, m_st;

  ap_handshake_profiler #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .prof_en(prof_en), .ap_start(ap_start),
    .ap_done(ap_done), .ap_continue(ap_continue), .iter_end(iter_end), .loop_block(loop_block),
    .busy(busy), .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_id(rec_id),
    .rec_latency(rec_latency), .rec_iters(rec_iters), .rec_stalls(rec_stalls), .drop_cnt(drop_cnt));

  ap_handshake_profiler #(.CNT_W(4), .DEPTH(DEPTH)) dut_s (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .prof_en(prof_en), .ap_start(ap_start),
    .ap_done(ap_done), .ap_continue(ap_continue), .iter_end(iter_end), .loop_block(loop_block),
    .busy(s_busy), .rec_valid(s_rec_valid), .rec_ready(rec_ready), .rec_id(s_rec_id),
    .rec_latency(s_rec_latency), .rec_iters(s_rec_iters), .rec_stalls(s_rec_stalls),
    .drop_cnt(s_drop_cnt));

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  function automatic longint sat(input longint v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic idle_inputs();
    ap_start = 0; ap_done = 0; ap_continue = 0; iter_end = 0; loop_block = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_id = 0; m_drop = 0; m_lat = 0; m_it = 0; m_st = 0;
  endtask

  // Advance the reference model by the current inputs, then clock the DUT.
  task automatic cycle();
    bit act, push, pop, full;
    rec_t r;
    act = 0; push = 0;
    pop = (mq.size() != 0) && rec_ready;
    if (m_state == 0 && prof_en && ap_start) begin
      act = 1; m_lat = 1; m_it = longint'(iter_end); m_st = longint'(loop_block);
    end else if (m_state == 1) begin
      act = 1;
      m_lat = sat(m_lat + 1);
      m_it  = sat(m_it + longint'(iter_end));
      m_st  = sat(m_st + longint'(loop_block));
    end
    if (act) begin
      if (ap_done) begin push = 1; m_state = ap_continue ? 0 : 2; end
      else m_state = 1;
    end else if (m_state == 2 && ap_continue) m_state = 0;
    full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (!full || pop) begin
        r.id = m_id; r.lat = m_lat; r.it = m_it; r.st = m_st;
        mq.push_back(r);
      end else if (m_drop < 65535) m_drop++;
      m_id = (m_id + 1) % 65536;
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic do_reset();
    ap_rst_n = 0; idle_inputs(); prof_en = 1; rec_ready = 0;
    model_reset();
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1;
  endtask

  task automatic test_reset();
    ap_rst_n = 0; idle_inputs(); prof_en = 1; rec_ready = 0;
    model_reset();
    repeat (2) @(posedge ap_clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", rec_valid); end
    checks++; if (rec_id !== 16'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", rec_id); end
    checks++; if (rec_latency !== '0 || rec_iters !== '0 || rec_stalls !== '0) begin
      errors++; $display("FAIL reset_fields: got %0d/%0d/%0d expected 0/0/0", rec_latency, rec_iters, rec_stalls);
    end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    ap_rst_n = 1;
    ap_start = 1; prof_en = 0;
    cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_start: busy got %0b expected 0", busy); end
    idle_inputs(); prof_en = 1;
  endtask

  task automatic test_single_run();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      ap_start = (c == 0); iter_end = (c == 2 || c == 4 || c == 6); loop_block = (c == 3 || c == 5);
      ap_done = (c == 9); ap_continue = (c == 9);
      cycle();
      if (c == 0) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b expected 1", busy); end
      end
      if (c == 8) begin
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b expected 0", rec_valid); end
      end
    end
    idle_inputs();
    checks++; if (rec_valid !== 1'b1 || rec_id !== 16'd0) begin
      errors++; $display("FAIL single_valid_id: got valid=%0b id=%0d expected 1/0", rec_valid, rec_id);
    end
    checks++; if (rec_latency !== 32'd10 || rec_iters !== 32'd3 || rec_stalls !== 32'd2) begin
      errors++; $display("FAIL single_fields: got %0d/%0d/%0d expected 10/3/2", rec_latency, rec_iters, rec_stalls);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %0b expected 0", busy); end
    rec_ready = 1; cycle(); rec_ready = 0;
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got %0b expected 0", rec_valid); end
  endtask

  task automatic test_continue_hold();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      ap_start = (c == 0 || c == 7); ap_done = (c == 5); ap_continue = (c == 8);
      cycle();
      checks++; if (busy !== (c < 8)) begin errors++; $display("FAIL hold_busy_c%0d: got %0b expected %0b", c, busy, (c < 8)); end
    end
    idle_inputs();
    checks++; if (rec_valid !== 1'b1 || rec_latency !== 32'd6) begin
      errors++; $display("FAIL hold_record: got valid=%0b lat=%0d expected 1/6", rec_valid, rec_latency);
    end
    rec_ready = 1; cycle(); rec_ready = 0;
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL hold_single_record: got valid=%0b expected 0", rec_valid); end
  endtask

  task automatic test_overflow();
    int exp_ids[4];
    exp_ids = '{1, 2, 3, 6};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      ap_start = 1; ap_done = 0; ap_continue = 0; cycle();
      ap_start = 0; ap_done = 1; ap_continue = 1; cycle();
    end
    idle_inputs();
    checks++; if (rec_valid !== 1'b1 || rec_id !== 16'd0) begin
      errors++; $display("FAIL ovf_head: got valid=%0b id=%0d expected 1/0", rec_valid, rec_id);
    end
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop: got %0d expected 2", drop_cnt); end
    ap_start = 1; cycle();
    ap_start = 0; ap_done = 1; ap_continue = 1; rec_ready = 1; cycle();
    idle_inputs(); rec_ready = 0;
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_pop_push_drop: got %0d expected 2", drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rec_valid !== 1'b1 || rec_id !== 16'(exp_ids[i])) begin
        errors++; $display("FAIL ovf_drain_%0d: got valid=%0b id=%0d expected 1/%0d", i, rec_valid, rec_id, exp_ids[i]);
      end
      rec_ready = 1; cycle(); rec_ready = 0;
    end
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %0b expected 0", rec_valid); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    ap_start = 1; ap_done = 1; ap_continue = 1; cycle();
    ap_done = 0; ap_continue = 0; cycle();
    ap_start = 0; cycle(); cycle();
    checks++; if (busy !== 1'b1 || rec_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got busy=%0b valid=%0b expected 1/1", busy, rec_valid);
    end
    ap_rst_n = 0; idle_inputs();
    #1;
    checks++; if (busy !== 1'b0 || rec_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_async: got busy=%0b valid=%0b expected 0/0", busy, rec_valid);
    end
    model_reset();
    @(posedge ap_clk); #1 ap_rst_n = 1;
    ap_start = 1; iter_end = 1; ap_done = 1; ap_continue = 1; cycle();
    idle_inputs();
    checks++; if (rec_valid !== 1'b1 || rec_id !== 16'd0 || rec_latency !== 32'd1 || rec_iters !== 32'd1) begin
      errors++; $display("FAIL midrst_after: got valid=%0b id=%0d lat=%0d it=%0d expected 1/0/1/1",
                         rec_valid, rec_id, rec_latency, rec_iters);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      ap_start = (c == 0); iter_end = 1; ap_done = (c == 19); ap_continue = (c == 19);
      cycle();
    end
    idle_inputs();
    checks++; if (s_rec_valid !== 1'b1 || s_rec_latency !== 4'd15 || s_rec_iters !== 4'd15) begin
      errors++; $display("FAIL sat_narrow: got valid=%0b lat=%0d it=%0d expected 1/15/15", s_rec_valid, s_rec_latency, s_rec_iters);
    end
    checks++; if (rec_latency !== 32'd20 || rec_iters !== 32'd20) begin
      errors++; $display("FAIL sat_wide: got lat=%0d it=%0d expected 20/20", rec_latency, rec_iters);
    end
    rec_ready = 1; cycle(); rec_ready = 0;
  endtask

  task automatic test_prof_en();
    do_reset();
    prof_en = 0;
    for (int c = 0; c < 12; c++) begin
      ap_start = (c % 3 == 0); ap_done = (c % 3 == 1); ap_continue = (c % 3 == 1);
      cycle();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_off_busy_c%0d: got %0b expected 0", c, busy); end
    end
    idle_inputs();
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL en_off_records: got valid=%0b expected 0", rec_valid); end
    prof_en = 1; ap_start = 1; cycle();
    prof_en = 0; ap_start = 0; cycle(); cycle(); cycle();
    ap_done = 1; ap_continue = 1; cycle();
    idle_inputs(); prof_en = 1;
    checks++; if (rec_valid !== 1'b1 || rec_id !== 16'd0 || rec_latency !== 32'd5) begin
      errors++; $display("FAIL en_drop_record: got valid=%0b id=%0d lat=%0d expected 1/0/5", rec_valid, rec_id, rec_latency);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      prof_en     = ($urandom_range(0, 9) != 0);
      ap_start    = $urandom_range(0, 1) == 1;
      ap_done     = ($urandom_range(0, 5) == 0);
      ap_continue = ($urandom_range(0, 2) == 0);
      iter_end    = $urandom_range(0, 1) == 1;
      loop_block  = ($urandom_range(0, 3) == 0);
      rec_ready   = ($urandom_range(0, 3) == 0);
      cycle();
      checks++; if (busy !== (m_state != 0)) begin
        errors++; $display("FAIL rnd_busy_n%0d: got %0b expected %0b", n, busy, (m_state != 0));
      end
      checks++; if (rec_valid !== (mq.size() != 0)) begin
        errors++; $display("FAIL rnd_valid_n%0d: got %0b expected %0b", n, rec_valid, (mq.size() != 0));
      end
      checks++; if (drop_cnt !== 16'(m_drop)) begin
        errors++; $display("FAIL rnd_drop_n%0d: got %0d expected %0d", n, drop_cnt, m_drop);
      end
      if (mq.size() != 0) begin
        checks++;
        if (rec_id !== 16'(mq[0].id) || rec_latency !== 32'(mq[0].lat) ||
            rec_iters !== 32'(mq[0].it) || rec_stalls !== 32'(mq[0].st)) begin
          errors++;
          $display("FAIL rnd_head_n%0d: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", n,
                   rec_id, rec_latency, rec_iters, rec_stalls, mq[0].id, mq[0].lat, mq[0].it, mq[0].st);
        end
      end
    end
    idle_inputs(); rec_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_continue_hold();
    test_overflow();
    test_reset_mid_run();
    test_saturation();
    test_prof_en();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
